// File: rtl/rx_frame_pkg.sv
// ----------------------------------------------------------------------------
// rx_frame_pkg
// Shared types and constants for the Ethernet receive framer:
//   - state_t      : framer state encoding
//   - PREAMBLE_BYTE, SFD_BYTE : start-of-frame delimiters
//   - HDR_LEN      : MAC header length (dst + src + EtherType)
//   - FCS_LEN      : trailing frame check sequence length
//   - CRC_RESIDUE  : CRC-32 register value after a good FCS (no final XOR)
//   - CRC_POLY_REFL: bit-reflected CRC-32 polynomial (0x04C11DB7 reversed)
// ----------------------------------------------------------------------------
package rx_frame_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        HEADER,
        PARAM,
        PAYLOAD,
        DROP,
        IGNORE
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam int          OFFSET_W      = 13;

endpackage

// File: rtl/crc32_d8.sv
// ----------------------------------------------------------------------------
// crc32_d8
// Byte-wide CRC-32 (reflected, poly 0x04C11DB7, init all-ones, no final XOR)
// with its state register. Only built when RX_FRAME_CRC_EN is defined.
// Ports:
//   rxclk  in  1  : clock
//   reset  in  1  : synchronous active-high, loads the init value
//   init   in  1  : load the init value (start of a new frame)
//   en     in  1  : fold `data` into the register this cycle
//   data   in  8  : byte, LSB first on the wire
//   crc    out 32 : current register value
// ----------------------------------------------------------------------------
`ifdef RX_FRAME_CRC_EN
module crc32_d8
    import rx_frame_pkg::*;
(
    input  logic        rxclk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // Eight serial LSB-first steps unrolled into one combinational function.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge rxclk) begin
        if (reset || init) begin
            crc <= '1;
        end else if (en) begin
            crc <= crc_next(crc, data);
        end
    end

endmodule
`endif

// File: rtl/rx_frame.sv
// ----------------------------------------------------------------------------
// rx_frame
// Byte-level Ethernet receive framer. Strips preamble/SFD and the MAC header,
// filters on EtherType, latches the divider byte and writes every following
// byte (samples and FCS) into the idle half of a double-buffered RAM. A frame
// that ends cleanly flips `bank` and publishes `div` / `cycle`.
//
// Optional feature: define RX_FRAME_CRC_EN to check the FCS (CRC-32 residue)
// before committing. Without it no CRC logic is built.
//
// Ports:
//   rxclk      in  1  : receive byte clock
//   reset      in  1  : synchronous active-high reset
//   rx_dv      in  1  : byte valid
//   rx_er      in  1  : receive error
//   rx_data    in  8  : received byte
//   dout       out 8  : RAM write data
//   addr       out 14 : RAM write address {write bank, offset}
//   we         out 1  : RAM write enable
//   bank       out 1  : bank holding the last committed frame
//   div        out 8  : divider of the last committed frame
//   cycle      out 14 : sample count of the last committed frame
//   frame_ok   out 1  : one-cycle commit pulse
//   frame_drop out 1  : one-cycle errored-frame pulse
// ----------------------------------------------------------------------------
module rx_frame
    import rx_frame_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MIN_PAYLOAD = 1
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rx_data,
    output logic [7:0]  dout,
    output logic [13:0] addr,
    output logic        we,
    output logic        bank,
    output logic [7:0]  div,
    output logic [13:0] cycle,
    output logic        frame_ok,
    output logic        frame_drop
);

    localparam logic [3:0] ET_HI_IDX = 4'(HDR_LEN - 2);
    localparam logic [3:0] ET_LO_IDX = 4'(HDR_LEN - 1);

    state_t              state;
    logic [3:0]          hdr_cnt;
    logic [OFFSET_W-1:0] offset;
    logic [7:0]          div_shadow;
    logic [13:0]         len;
    logic                len_ok;
    logic                crc_ok;

    // The FCS bytes sit in the payload region but are not samples.
    assign len    = {1'b0, offset} - 14'(FCS_LEN);
    assign len_ok = {1'b0, offset} >= 14'(FCS_LEN + MIN_PAYLOAD);

`ifdef RX_FRAME_CRC_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;

    // Restart on the SFD so the CRC covers destination MAC through FCS.
    assign crc_init = (state == PREAMBLE) && rx_dv && !rx_er && (rx_data == SFD_BYTE);
    assign crc_en   = rx_dv && !rx_er &&
                      ((state == HEADER) || (state == PARAM) || (state == PAYLOAD));

    crc32_d8 u_crc (
        .rxclk (rxclk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (rx_data),
        .crc   (crc)
    );

    assign crc_ok = (crc == CRC_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    // NOTE: all state below is sequential and uses non-blocking assignments;
    // the defaults at the top of the else branch make we/frame_ok/frame_drop
    // single-cycle pulses without any extra clear logic.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state      <= WAIT_IDLE;
            hdr_cnt    <= '0;
            offset     <= '0;
            div_shadow <= '0;
            dout       <= '0;
            addr       <= '0;
            we         <= 1'b0;
            bank       <= 1'b0;
            div        <= '0;
            cycle      <= '0;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;

            case (state)
                // Entered from reset: never start mid-frame.
                WAIT_IDLE: begin
                    if (!rx_dv) state <= IDLE;
                end

                IDLE: begin
                    if (rx_dv && (rx_data == PREAMBLE_BYTE)) state <= PREAMBLE;
                end

                PREAMBLE: begin
                    if (!rx_dv) begin
                        state      <= IDLE;
                        frame_drop <= 1'b1;
                    end else if (rx_er) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end else if (rx_data == SFD_BYTE) begin
                        state   <= HEADER;
                        hdr_cnt <= '0;
                    end else if (rx_data != PREAMBLE_BYTE) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end
                end

                HEADER: begin
                    if (!rx_dv) begin
                        state      <= IDLE;
                        frame_drop <= 1'b1;
                    end else if (rx_er) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end else begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                        // Foreign EtherType: silently skip the rest of the frame.
                        if (((hdr_cnt == ET_HI_IDX) && (rx_data != ETHERTYPE[15:8])) ||
                            ((hdr_cnt == ET_LO_IDX) && (rx_data != ETHERTYPE[7:0]))) begin
                            state <= IGNORE;
                        end else if (hdr_cnt == ET_LO_IDX) begin
                            state <= PARAM;
                        end
                    end
                end

                PARAM: begin
                    if (!rx_dv) begin
                        state      <= IDLE;
                        frame_drop <= 1'b1;
                    end else if (rx_er) begin
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end else begin
                        div_shadow <= rx_data;
                        offset     <= '0;
                        state      <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (!rx_dv) begin
                        // End of frame: publish only a clean, long-enough frame.
                        state <= IDLE;
                        if (len_ok && crc_ok) begin
                            bank     <= ~bank;
                            div      <= div_shadow;
                            cycle    <= len;
                            frame_ok <= 1'b1;
                        end else begin
                            frame_drop <= 1'b1;
                        end
                    end else if (rx_er || (offset == '1)) begin
                        // The last offset is never written: it marks overflow.
                        state      <= DROP;
                        frame_drop <= 1'b1;
                    end else begin
                        we     <= 1'b1;
                        dout   <= rx_data;
                        addr   <= {~bank, offset};
                        offset <= offset + 1'b1;
                    end
                end

                DROP, IGNORE: begin
                    if (!rx_dv) state <= IDLE;
                end

                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_rx_frame
// Randomized frames (random MACs, samples, EtherType, errors) driven into
// rx_frame and compared against a frame-level reference model: the model
// decides from the frame contents whether it is ignored, dropped or
// committed, which RAM writes it produces and what bank/div/cycle become.
// ----------------------------------------------------------------------------
module tb_rx_frame;

    localparam logic [15:0] ETYPE   = 16'h88B5;
    localparam int          MIN_PL  = 1;
    localparam int          HDR_DIV = 15;  // bytes after SFD before first sample
`ifdef RX_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  dout;
    logic [13:0] addr;
    logic        we;
    logic        bank;
    logic [7:0]  div;
    logic [13:0] cycle;
    logic        frame_ok;
    logic        frame_drop;

    rx_frame #(
        .ETHERTYPE   (ETYPE),
        .MIN_PAYLOAD (MIN_PL)
    ) dut (
        .rxclk      (rxclk),
        .reset      (reset),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .rx_data    (rx_data),
        .dout       (dout),
        .addr       (addr),
        .we         (we),
        .bank       (bank),
        .div        (div),
        .cycle      (cycle),
        .frame_ok   (frame_ok),
        .frame_drop (frame_drop)
    );

    always #4 rxclk = ~rxclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the inactive edge.
    logic [21:0] wr_q[$];
    int          ok_seen   = 0;
    int          drop_seen = 0;

    always @(negedge rxclk) begin
        if (we === 1'b1) wr_q.push_back({addr, dout});
        if (frame_ok === 1'b1) ok_seen++;
        if (frame_drop === 1'b1) drop_seen++;
    end

    // Reference state: what the last committed frame published.
    logic        m_bank  = 1'b0;
    logic [7:0]  m_div   = 8'h00;
    logic [13:0] m_cycle = 14'h0;

    // Bytes after the SFD of the frame under test.
    logic [7:0] fr[$];

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build_frame(input logic [15:0] et, input logic [7:0] div_val,
                               input int n, input bit bad);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < 12; i++) fr.push_back(8'($urandom));
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        fr.push_back(div_val);
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
        c = 32'hFFFFFFFF;
        foreach (fr[i]) c = crc_byte(c, fr[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
        if (bad && n > 0) fr[HDR_DIV + n/2] = fr[HDR_DIV + n/2] ^ 8'h10;
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge rxclk);
        rx_dv   = dv;
        rx_er   = er;
        rx_data = d;
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
    endtask

    // One frame: build, drive, predict, compare.
    task automatic run_frame(input string name, input logic [15:0] et, input logic [7:0] div_val,
                             input int n, input bit bad_in, input int er_idx);
        int   ok0, drop0, wr0, got_wr, exp_wr, mism, pl;
        bit   bad, exp_ok, exp_drop, chk_end;
        logic end_ok, end_drop, bank0;
        logic [21:0] e;

        bad = bad_in && (n > 0);
        build_frame(et, div_val, n, bad);
        @(negedge rxclk); #1;
        ok0 = ok_seen; drop0 = drop_seen; wr0 = wr_q.size();
        bank0 = m_bank;

        send_preamble();
        for (int i = 0; i < fr.size(); i++)
            drive(1'b1, (er_idx >= 0 && i == HDR_DIV + er_idx) ? 1'b1 : 1'b0, fr[i]);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge rxclk); #1;
        end_ok = frame_ok; end_drop = frame_drop;
        repeat (2) @(negedge rxclk);
        #1;

        // Reference decision from the frame contents.
        pl = n + 4;
        exp_ok = 1'b0; exp_drop = 1'b0; chk_end = 1'b1;
        if (et != ETYPE) begin
            exp_wr = 0;
        end else if (er_idx >= 0) begin
            exp_wr = er_idx; exp_drop = 1'b1; chk_end = 1'b0;
        end else if (pl >= 8192) begin
            exp_wr = 8191; exp_drop = 1'b1; chk_end = 1'b0;
        end else begin
            exp_wr = pl;
            if (n >= MIN_PL && !(CRC_ON && bad)) exp_ok = 1'b1;
            else exp_drop = 1'b1;
        end

        got_wr = wr_q.size() - wr0;
        mism = 0;
        for (int i = 0; i < got_wr && i < exp_wr; i++) begin
            e = {~bank0, 13'(i), fr[HDR_DIV + i]};
            if (wr_q[wr0 + i] !== e) mism++;
        end

        check({name, ".ok_pulses"}, 32'(ok_seen - ok0), 32'(exp_ok));
        check({name, ".drop_pulses"}, 32'(drop_seen - drop0), 32'(exp_drop));
        if (chk_end) check({name, ".eof_pulse"}, {30'h0, end_ok, end_drop}, {30'h0, exp_ok, exp_drop});
        check({name, ".wr_count"}, 32'(got_wr), 32'(exp_wr));
        check({name, ".wr_data"}, 32'(mism), 32'd0);

        if (exp_ok) begin
            m_bank  = ~m_bank;
            m_div   = div_val;
            m_cycle = 14'(n);
        end
        check({name, ".bank"}, 32'(bank), 32'(m_bank));
        check({name, ".div"}, 32'(div), 32'(m_div));
        check({name, ".cycle"}, 32'(cycle), 32'(m_cycle));
        wr_q.delete();
    endtask

    // Reset pulsed at payload byte 50 while rx_dv stays high.
    task automatic reset_mid_frame();
        int ok0, drop0, wr0;
        build_frame(ETYPE, 8'h09, 100, 1'b0);
        ok0 = 0; drop0 = 0; wr0 = 0;
        send_preamble();
        for (int i = 0; i < fr.size(); i++) begin
            drive(1'b1, 1'b0, fr[i]);
            if (i == HDR_DIV + 50) reset = 1'b1;
            if (i == HDR_DIV + 53) begin
                #1;
                check("rst_mid.outputs",
                      {dout, addr[7:0], we, bank, frame_ok, frame_drop},
                      32'h0);
                check("rst_mid.addr_div_cycle", {addr[13:8], div, cycle}, 32'h0);
                m_bank = 1'b0; m_div = 8'h00; m_cycle = 14'h0;
                ok0 = ok_seen; drop0 = drop_seen; wr0 = wr_q.size();
                reset = 1'b0;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge rxclk);
        #1;
        check("rst_mid.ok_after", 32'(ok_seen - ok0), 32'd0);
        check("rst_mid.drop_after", 32'(drop_seen - drop0), 32'd0);
        check("rst_mid.wr_after", 32'(wr_q.size() - wr0), 32'd0);
        check("rst_mid.bank", 32'(bank), 32'(m_bank));
        wr_q.delete();
    endtask

    initial begin
        int          r, n, er;
        bit          bad;
        logic [15:0] et;

        repeat (3) @(negedge rxclk);
        #1;
        check("reset.outputs", {dout, we, bank, div, frame_ok, frame_drop}, 32'h0);
        check("reset.addr_cycle", {4'h0, addr, cycle}, 32'h0);
        @(negedge rxclk);
        reset = 1'b0;
        repeat (2) @(negedge rxclk);

        run_frame("valid",      ETYPE,    8'h04, 100, 1'b0, -1);
        run_frame("etype0800",  16'h0800, 8'h07, 100, 1'b0, -1);
        run_frame("bitflip",    ETYPE,    8'h04, 100, 1'b1, -1);
        run_frame("rx_er10",    ETYPE,    8'h05, 100, 1'b0, 10);
        run_frame("after_er",   ETYPE,    8'h06, 100, 1'b0, -1);
        run_frame("len0",       ETYPE,    8'h11, 0,   1'b0, -1);
        run_frame("len1",       ETYPE,    8'h12, 1,   1'b0, -1);
        run_frame("overflow",   ETYPE,    8'h13, 8200, 1'b0, -1);
        run_frame("max_len",    ETYPE,    8'h14, 8187, 1'b0, -1);
        reset_mid_frame();
        run_frame("after_rst",  ETYPE,    8'h21, 60,  1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            r   = $urandom_range(0, 7);
            et  = (r == 0) ? 16'h0800 : (r == 1) ? 16'h88B4 : ETYPE;
            n   = $urandom_range(0, 40);
            bad = ($urandom_range(0, 3) == 0);
            er  = (n > 2 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            run_frame($sformatf("rand%0d", k), et, 8'($urandom), n, bad, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
